// File: rtl/fault_countdown_seq_pkg.sv
// Shared types, state encodings and helpers for the fault-vote countdown sequencer.
package fcs_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Counts set bits among the low n bits of v.
    function automatic int popcount(input logic [31:0] v, input int n);
        int c;
        c = 0;
        for (int i = 0; i < 32; i++) begin
            if (i < n && v[i]) c = c + 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/fault_countdown_seq_debounce_ch.sv
// One debounced switch channel: the output follows the raw input only after
// DB_TICKS consecutive differing ticks.
module debounce_ch #(
    parameter int DB_TICKS = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic in,
    output logic out
);
    localparam int CW = $clog2(DB_TICKS + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= 1'b0;
            cnt <= '0;
        end else if (tick) begin
            if (in == out) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_TICKS - 1)) begin
                out <= ~out;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fault_countdown_seq.sv
// Fault-vote countdown sequencer: debounced K-of-N fault vote gating a blinking
// LED-bar countdown that latches DONE when the bar empties.
module fault_countdown_seq
    import fcs_pkg::*;
#(
    parameter int N_IN        = 3,
    parameter int K_VOTE      = 2,
    parameter int W           = 8,
    parameter int DB_TICKS    = 3,
    parameter int STEP_TICKS  = 100,
    parameter int BLINK_TICKS = 33
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick,
    input  logic [N_IN-1:0] fault_raw,
    input  logic            arm_raw,
    output logic [N_IN-1:0] fault_db,
    output logic            vote,
    output logic [1:0]      state,
    output logic            done,
    output logic [W-1:0]    leds
);
    localparam int SCW = $clog2(STEP_TICKS + 1);
    localparam int BCW = $clog2(BLINK_TICKS + 1);

    logic           arm_db;
    logic [W-1:0]   bar, bar_n;
    logic [SCW-1:0] step_cnt, step_n;
    logic [BCW-1:0] blink_cnt, blink_n;
    logic           phase, phase_n;
    logic [1:0]     state_n;
    logic [W-1:0]   leds_n;
    logic           last_step;

    for (genvar i = 0; i < N_IN; i++) begin : g_fault_db
        debounce_ch #(.DB_TICKS(DB_TICKS)) u_db (
            .clk (clk),
            .rst (rst),
            .tick(tick),
            .in  (fault_raw[i]),
            .out (fault_db[i])
        );
    end

    debounce_ch #(.DB_TICKS(DB_TICKS)) u_arm_db (
        .clk (clk),
        .rst (rst),
        .tick(tick),
        .in  (arm_raw),
        .out (arm_db)
    );

    assign done      = (state == ST_DONE);
    assign last_step = (state == ST_COUNT) && tick && (step_cnt == SCW'(STEP_TICKS - 1));

    always_comb begin
        state_n = state;
        bar_n   = bar;
        step_n  = step_cnt;
        blink_n = blink_cnt;
        phase_n = phase;

        // The blink timebase free-runs on tick regardless of state.
        if (tick) begin
            if (blink_cnt == BCW'(BLINK_TICKS - 1)) begin
                blink_n = '0;
                phase_n = ~phase;
            end else begin
                blink_n = blink_cnt + 1'b1;
            end
        end

        if (state == ST_DONE) begin
            state_n = ST_DONE;
        end else if (!arm_db) begin
            state_n = ST_IDLE;
            bar_n   = '1;
            step_n  = '0;
        end else begin
            // A step due on this edge is applied even if the vote just dropped.
            if (last_step) begin
                bar_n  = bar >> 1;
                step_n = '0;
            end else if (state == ST_COUNT && tick) begin
                step_n = step_cnt + 1'b1;
            end

            if (last_step && bar == W'(1)) begin
                state_n = ST_DONE;
            end else if (vote) begin
                state_n = ST_COUNT;
            end else if (state == ST_COUNT) begin
                state_n = ST_HOLD;
            end
        end
    end

    always_comb begin
        leds_n = '0;
        case (state_n)
            ST_IDLE:  leds_n = '0;
            ST_COUNT: leds_n = phase_n ? bar_n : '0;
            ST_HOLD:  leds_n = bar_n;
            default:  leds_n = '1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vote      <= 1'b0;
            state     <= ST_IDLE;
            bar       <= '1;
            step_cnt  <= '0;
            blink_cnt <= '0;
            phase     <= 1'b1;
            leds      <= '0;
        end else begin
            vote      <= (popcount(32'(fault_db), N_IN) >= K_VOTE);
            state     <= state_n;
            bar       <= bar_n;
            step_cnt  <= step_n;
            blink_cnt <= blink_n;
            phase     <= phase_n;
            leds      <= leds_n;
        end
    end

endmodule

// File: tb/tb_fault_countdown_seq.sv
// Randomized bench for fault_countdown_seq: a tick-level behavioural model feeds
// an expected queue that a negedge monitor drains against the DUT outputs.
module tb_fault_countdown_seq;
    localparam int N_IN        = 3;
    localparam int K_VOTE      = 2;
    localparam int W           = 8;
    localparam int DB_TICKS    = 3;
    localparam int STEP_TICKS  = 4;
    localparam int BLINK_TICKS = 2;

    localparam int S_IDLE  = 0;
    localparam int S_COUNT = 1;
    localparam int S_HOLD  = 2;
    localparam int S_DONE  = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            tick = 1'b0;
    logic [N_IN-1:0] fault_raw = '0;
    logic            arm_raw = 1'b0;
    logic [N_IN-1:0] fault_db;
    logic            vote;
    logic [1:0]      state;
    logic            done;
    logic [W-1:0]    leds;

    fault_countdown_seq #(
        .N_IN(N_IN), .K_VOTE(K_VOTE), .W(W), .DB_TICKS(DB_TICKS),
        .STEP_TICKS(STEP_TICKS), .BLINK_TICKS(BLINK_TICKS)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .fault_raw(fault_raw), .arm_raw(arm_raw),
        .fault_db(fault_db), .vote(vote), .state(state), .done(done), .leds(leds)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    logic [14:0] exp_q[$];

    // Reference model: channel index N_IN is the arm switch.
    int m_db_cnt[N_IN+1];
    bit m_db[N_IN+1];
    bit m_vote;
    int m_state;
    int m_elapsed;   // COUNT ticks spent in the current countdown
    int m_ticks;     // ticks since reset, drives the blink phase

    function automatic void model_reset();
        for (int c = 0; c <= N_IN; c++) begin
            m_db_cnt[c] = 0;
            m_db[c] = 1'b0;
        end
        m_vote = 1'b0;
        m_state = S_IDLE;
        m_elapsed = 0;
        m_ticks = 0;
    endfunction

    function automatic void model_step(input bit t, input logic [N_IN-1:0] f_raw, input bit a_raw);
        logic [N_IN-1:0] f_old;
        bit arm_old, vote_old, raw;
        int st_old;
        for (int c = 0; c < N_IN; c++) f_old[c] = m_db[c];
        arm_old = m_db[N_IN];
        vote_old = m_vote;
        st_old = m_state;
        if (t) begin
            m_ticks++;
            for (int c = 0; c <= N_IN; c++) begin
                raw = (c < N_IN) ? f_raw[c] : a_raw;
                if (raw == m_db[c]) begin
                    m_db_cnt[c] = 0;
                end else begin
                    m_db_cnt[c]++;
                    if (m_db_cnt[c] == DB_TICKS) begin
                        m_db[c] = raw;
                        m_db_cnt[c] = 0;
                    end
                end
            end
        end
        m_vote = ($countones(f_old) >= K_VOTE);
        if (st_old != S_DONE) begin
            if (!arm_old) begin
                m_state = S_IDLE;
                m_elapsed = 0;
            end else begin
                if (st_old == S_COUNT && t) m_elapsed++;
                if (m_elapsed == W * STEP_TICKS) m_state = S_DONE;
                else if (vote_old) m_state = S_COUNT;
                else if (st_old == S_COUNT) m_state = S_HOLD;
            end
        end
    endfunction

    function automatic logic [14:0] model_outputs();
        logic [W-1:0] bar, l;
        logic [N_IN-1:0] f;
        bit ph;
        bar = 8'hFF >> (m_elapsed / STEP_TICKS);
        ph = ((m_ticks / BLINK_TICKS) % 2) == 0;
        case (m_state)
            S_IDLE:  l = '0;
            S_COUNT: l = ph ? bar : '0;
            S_HOLD:  l = bar;
            default: l = '1;
        endcase
        for (int c = 0; c < N_IN; c++) f[c] = m_db[c];
        return {f, m_vote, 2'(m_state), (m_state == S_DONE), l};
    endfunction

    always @(posedge clk) begin
        if (rst) model_reset();
        else model_step(tick, fault_raw, arm_raw);
        exp_q.push_back(model_outputs());
    end

    logic [14:0] mon_exp, mon_act;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {fault_db, vote, state, done, leds};
            checks++;
            if (mon_act === mon_exp) passed++;
            else $display("FAIL outputs t=%0t got fdb=%b vote=%b st=%0d done=%b leds=%h expected fdb=%b vote=%b st=%0d done=%b leds=%h",
                          $time, mon_act[14:12], mon_act[11], mon_act[10:9], mon_act[8], mon_act[7:0],
                          mon_exp[14:12], mon_exp[11], mon_exp[10:9], mon_exp[8], mon_exp[7:0]);
        end
    end

    int clk_phase = 0;

    task automatic run_clks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tick = (clk_phase == 3);
            clk_phase = (clk_phase + 1) % 4;
        end
    endtask

    task automatic run_ticks(input int n);
        run_clks(4 * n);
    endtask

    task automatic check_now(input string name, input logic [14:0] act, input logic [14:0] exp_v);
        checks++;
        if (act === exp_v) passed++;
        else $display("FAIL %s t=%0t got %h expected %h", name, $time, act, exp_v);
    endtask

    // rst rises between edges; outputs must clear before any clock edge.
    task automatic async_reset_pulse(input string name);
        #2 rst = 1'b1;
        #1 check_now(name, {fault_db, vote, state, done, leds}, 15'h0);
        run_clks(1);
        rst = 1'b0;
    endtask

    initial begin
        run_clks(3);
        rst = 1'b0;
        check_now("reset_state", {fault_db, vote, state, done, leds}, 15'h0);

        // glitch rejection, then a real 3-tick press
        fault_raw = 3'b001;
        run_ticks(2);
        fault_raw = 3'b000;
        run_ticks(3);
        check_now("glitch_rejected", {12'h0, fault_db}, 15'h0);
        fault_raw = 3'b001;
        run_ticks(4);

        // one fault is below threshold
        arm_raw = 1'b1;
        run_ticks(6);
        check_now("single_fault_idle", {4'h0, vote, state, leds}, 15'h0);

        // full countdown to DONE, then inputs no longer matter
        fault_raw = 3'b011;
        run_ticks(40);
        check_now("countdown_done", {4'h0, state, done, leds}, {4'h0, 2'd3, 1'b1, 8'hFF});
        arm_raw = 1'b0;
        fault_raw = 3'b000;
        run_ticks(6);
        check_now("done_latched", {4'h0, state, done, leds}, {4'h0, 2'd3, 1'b1, 8'hFF});
        async_reset_pulse("async_reset_in_done");

        // hold / resume / disarm
        arm_raw = 1'b1;
        fault_raw = 3'b110;
        run_ticks(12);
        fault_raw = 3'b100;
        run_ticks(8);
        fault_raw = 3'b111;
        run_ticks(10);
        arm_raw = 1'b0;
        run_ticks(6);
        arm_raw = 1'b1;
        run_ticks(14);

        for (int seg = 0; seg < 200; seg++) begin
            fault_raw = 3'($urandom_range(0, 7));
            arm_raw = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 4) == 0) run_clks($urandom_range(1, 10));
            else run_ticks($urandom_range(1, 12));
            if ($urandom_range(0, 39) == 0) async_reset_pulse("async_reset_random");
        end

        fault_raw = 3'b000;
        arm_raw = 1'b0;
        run_clks(4);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
